// File: rtl/sensor_pkg.sv
// Shared types and defaults for the sensor frame collector.
package sensor_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int MAX_VAL_DEF = 100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PEND    = 2'd2
    } col_state_t;

    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sensor_frame_collector_if.sv
// Sample-in / frame-out handshake bundle for the sensor frame collector.
interface sensor_frame_collector_if
    import sensor_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_CH = 2
) ();

    localparam int CH_W = ch_width(NUM_CH);

    logic                     in_valid;
    logic                     in_ready;
    logic [CH_W-1:0]          in_ch;
    logic [DATA_W-1:0]        in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_CH*DATA_W-1:0] out_frame;
    logic                     zero_err;
    logic                     tmo_err;
    logic                     ch_err;

    modport master (
        output in_valid, in_ch, in_data, out_ready,
        input  in_ready, out_valid, out_frame, zero_err, tmo_err, ch_err
    );

    modport slave (
        input  in_valid, in_ch, in_data, out_ready,
        output in_ready, out_valid, out_frame, zero_err, tmo_err, ch_err
    );

endinterface

// File: rtl/sensor_frame_collector_timer.sv
// Partial-frame timeout: down-counter reloaded by clear, expire at terminal count.
module frame_timeout_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LOAD = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
    localparam bit ENABLED = (TIMEOUT_CYC != 0);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= LOAD;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Zero count corresponds to TIMEOUT_CYC-1 cycles spent collecting.
    assign expire = ENABLED && run && (cnt == '0);

endmodule

// File: rtl/sensor_frame_collector.sv
// Collects one sample per channel into a frame; optional clamp via SENSOR_RANGE_CLAMP_EN.
// state   | meaning
// IDLE    | no partial frame, timer held cleared
// COLLECT | partial frame being assembled, timer running
// PEND    | frame complete, waiting for the output register to free up
module sensor_frame_collector
    import sensor_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NUM_CH      = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_VAL     = MAX_VAL_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    sensor_frame_collector_if.slave bus
);

    localparam int FRAME_W = NUM_CH * DATA_W;

    col_state_t          state;
    logic [FRAME_W-1:0]  asm_frame;
    logic [NUM_CH-1:0]   mask;
    logic [FRAME_W-1:0]  out_frame_q;
    logic                out_valid_q;
    logic                in_ready_q;
    logic                zero_err_q;
    logic                tmo_err_q;
    logic                ch_err_q;

    logic                accept;
    logic                ch_legal;
    logic [DATA_W-1:0]   sample;
    logic [FRAME_W-1:0]  asm_next;
    logic [NUM_CH-1:0]   mask_next;
    logic                any_zero;
    logic                out_free;
    logic                tmr_run;
    logic                tmr_clear;
    logic                expire;

    always_comb begin
        accept   = bus.in_valid && in_ready_q;
        ch_legal = int'(bus.in_ch) < NUM_CH;
`ifdef SENSOR_RANGE_CLAMP_EN
        sample = (bus.in_data > DATA_W'(MAX_VAL)) ? DATA_W'(MAX_VAL) : bus.in_data;
`else
        sample = bus.in_data;
`endif
        asm_next  = asm_frame;
        mask_next = mask;
        for (int k = 0; k < NUM_CH; k++) begin
            if (accept && (int'(bus.in_ch) == k)) begin
                asm_next[k*DATA_W +: DATA_W] = sample;
                mask_next[k]                 = 1'b1;
            end
        end
        any_zero = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (asm_next[k*DATA_W +: DATA_W] == '0) any_zero = 1'b1;
        end
        out_free  = !out_valid_q || bus.out_ready;
        tmr_run   = (state == COLLECT);
        tmr_clear = (state != COLLECT);
    end

    frame_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (tmr_run),
        .clear  (tmr_clear),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            asm_frame   <= '0;
            mask        <= '0;
            out_frame_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            zero_err_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
            ch_err_q    <= 1'b0;
        end else begin
            zero_err_q <= 1'b0;
            tmo_err_q  <= 1'b0;
            ch_err_q   <= accept && !ch_legal;
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept && ch_legal) begin
                        asm_frame <= asm_next;
                        mask      <= mask_next;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    // Timeout wins over a sample arriving in the same cycle.
                    if (expire) begin
                        tmo_err_q <= 1'b1;
                        mask      <= '0;
                        state     <= IDLE;
                    end else if (accept && ch_legal) begin
                        asm_frame <= asm_next;
                        mask      <= mask_next;
                        if (&mask_next) begin
                            if (any_zero) begin
                                zero_err_q <= 1'b1;
                                mask       <= '0;
                                state      <= IDLE;
                            end else begin
                                in_ready_q <= 1'b0;
                                state      <= PEND;
                            end
                        end
                    end
                end
                PEND: begin
                    if (out_free) begin
                        out_frame_q <= asm_frame;
                        out_valid_q <= 1'b1;
                        mask        <= '0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    mask       <= '0;
                    in_ready_q <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_frame = out_frame_q;
    assign bus.zero_err  = zero_err_q;
    assign bus.tmo_err   = tmo_err_q;
    assign bus.ch_err    = ch_err_q;

endmodule
